// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// burst-engine state encodings.
package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_next.sv
// Combinational next-value generator shared by the single-step and burst paths.
// Each bit picks from its own value, its lower or upper neighbour, a serial input or d.
module shift_next
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] nxt
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic lo_shift;
            logic lo_rot;
            logic hi_shift;
            logic hi_rot;
            logic hi_asr;
            logic bit_nxt;

            // End bits take their neighbour from the serial inputs or the opposite end.
            if (gi == 0) begin : g_lsb
                assign lo_shift = sin_r;
                assign lo_rot   = q[WIDTH-1];
            end else begin : g_lo
                assign lo_shift = q[gi-1];
                assign lo_rot   = q[gi-1];
            end

            if (gi == WIDTH-1) begin : g_msb
                assign hi_shift = sin_l;
                assign hi_rot   = q[0];
                assign hi_asr   = q[WIDTH-1];
            end else begin : g_hi
                assign hi_shift = q[gi+1];
                assign hi_rot   = q[gi+1];
                assign hi_asr   = q[gi+1];
            end

            always_comb begin
                bit_nxt = q[gi];
                case (mode)
                    MODE_HOLD: bit_nxt = q[gi];
                    MODE_LOAD: bit_nxt = d[gi];
                    MODE_SHL:  bit_nxt = lo_shift;
                    MODE_SHR:  bit_nxt = hi_shift;
                    MODE_ROL:  bit_nxt = lo_rot;
                    MODE_ROR:  bit_nxt = hi_rot;
                    MODE_ASR:  bit_nxt = hi_asr;
                    MODE_CLR:  bit_nxt = 1'b0;
                    default:   bit_nxt = q[gi];
                endcase
            end

            assign nxt[gi] = bit_nxt;
        end
    endgenerate

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register with single-step operations and a burst engine
// that repeats one latched operation burst_len times, reporting busy/done.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [2:0]       op_sel;
    logic             busy_q;
    logic             done_q;

    // During a burst the latched operation drives the datapath, not the live mode input.
    assign op_sel = (state_q == ST_RUN) ? op_q : mode;

    shift_next #(
        .WIDTH (WIDTH)
    ) u_shift_next (
        .q     (data_q),
        .mode  (op_sel),
        .d     (d),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .nxt   (data_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= MODE_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q  <= mode;
                        cnt_q <= burst_len;
                        if (burst_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else if (en) begin
                        data_q <= data_d;
                    end
                end
                ST_RUN: begin
                    // cnt is nonzero on entry, so the decrement can never wrap.
                    if (en && (cnt_q != '0)) begin
                        data_q <= data_d;
                        cnt_q  <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q      = data_q;
    assign sout_l = data_q[WIDTH-1];
    assign sout_r = data_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8).
module tb_univ_shift_reg;
    import univ_shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic       start;
    logic [3:0] burst_len;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .start     (start),
        .burst_len (burst_len),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        start = 1'b0; en = 1'b1; mode = MODE_LOAD; d = val;
        step();
        en = 1'b0; mode = MODE_HOLD;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;
        start = 1'b0; burst_len = '0;
        step(); step();
        @(negedge clk) rst = 1'b0;
        #1;
        n_checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_init: got q=%h busy=%b done=%b expected q=00 busy=0 done=0", q, busy, done); else n_pass++;
        load(8'hA5);
        n_checks++; if (q !== 8'hA5) $display("FAIL preload_a5: got %h expected a5", q); else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL async_reset: got q=%h busy=%b done=%b expected q=00 busy=0 done=0", q, busy, done); else n_pass++;
        @(negedge clk) rst = 1'b0;
        #1;
        load(8'h3C);
        n_checks++; if (q !== 8'h3C) $display("FAIL load_3c: got %h expected 3c", q); else n_pass++;
        $display("reset: async clear then load 3c -> q=%h", q);
    endtask

    task automatic test_single_step();
        logic [2:0] modes [8] = '{MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR, MODE_HOLD, MODE_LOAD};
        logic [7:0] exps  [8] = '{8'h2D, 8'h4B, 8'h2D, 8'h4B, 8'hCB, 8'h00, 8'h96, 8'h96};
        logic       ens   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            load(8'h96);
            if (i == 0) begin
                n_checks++; if (sout_l !== 1'b1 || sout_r !== 1'b0)
                    $display("FAIL sout_96: got l=%b r=%b expected l=1 r=0", sout_l, sout_r); else n_pass++;
            end
            mode = modes[i]; en = ens[i]; sin_r = 1'b1; sin_l = 1'b0; d = 8'hFF;
            step();
            n_checks++; if (q !== exps[i])
                $display("FAIL single_step mode=%0d en=%b: got %h expected %h", modes[i], ens[i], q, exps[i]); else n_pass++;
            $display("single: 96 mode=%0d en=%b -> q=%h", modes[i], ens[i], q);
            en = 1'b0; sin_r = 1'b0;
        end
    endtask

    task automatic test_burst_serialise();
        logic [7:0] pat = 8'hB4;
        load(8'hB4);
        start = 1'b1; mode = MODE_SHL; sin_r = 1'b0; burst_len = 4'd8; en = 1'b1;
        step();
        start = 1'b0; mode = MODE_HOLD;
        n_checks++; if (q !== 8'hB4) $display("FAIL serialise_start_q: got %h expected b4", q); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (sout_l !== pat[7-i] || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL serialise_bit%0d: got sout_l=%b busy=%b done=%b expected %b 1 0", i, sout_l, busy, done, pat[7-i]); else n_pass++;
            step();
        end
        n_checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b1)
            $display("FAIL serialise_end: got q=%h busy=%b done=%b expected 00 0 1", q, busy, done); else n_pass++;
        step();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL serialise_done_pulse: got done=%b busy=%b expected 0 0", done, busy); else n_pass++;
        $display("burst serialise: b4 SHL x8 -> q=%h", q);
        en = 1'b0;
    endtask

    task automatic test_burst_stalls();
        logic       ens   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] exq   [5] = '{8'h80, 8'h80, 8'h40, 8'h40, 8'h20};
        logic       exbsy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exdn  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        load(8'h01);
        start = 1'b1; mode = MODE_ROR; burst_len = 4'd3; en = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = ens[i]; mode = MODE_LOAD; d = 8'hFF;
            step();
            n_checks++; if (q !== exq[i] || busy !== exbsy[i] || done !== exdn[i])
                $display("FAIL stall_cycle%0d: got q=%h busy=%b done=%b expected %h %b %b", i, q, busy, done, exq[i], exbsy[i], exdn[i]); else n_pass++;
            $display("burst stall: cycle %0d en=%b -> q=%h busy=%b done=%b", i, ens[i], q, busy, done);
        end
        en = 1'b0; mode = MODE_HOLD;
        step();
    endtask

    task automatic test_edge_cases();
        // zero-length burst; en in DONE must be ignored
        load(8'h5A);
        start = 1'b1; burst_len = 4'd0; mode = MODE_CLR; en = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h5A)
            $display("FAIL zero_len: got done=%b busy=%b q=%h expected 1 0 5a", done, busy, q); else n_pass++;
        step();
        n_checks++; if (done !== 1'b0 || q !== 8'h5A)
            $display("FAIL zero_len_after: got done=%b q=%h expected 0 5a", done, q); else n_pass++;
        en = 1'b0;
        $display("edge: zero-length burst -> q=%h", q);
        // start and en together: no single-step op
        start = 1'b1; mode = MODE_LOAD; d = 8'hFF; burst_len = 4'd1; en = 1'b1;
        step();
        start = 1'b0; d = 8'h33;
        n_checks++; if (q !== 8'h5A || busy !== 1'b1)
            $display("FAIL start_priority: got q=%h busy=%b expected 5a 1", q, busy); else n_pass++;
        step();
        n_checks++; if (q !== 8'h33 || done !== 1'b1)
            $display("FAIL burst_load: got q=%h done=%b expected 33 1", q, done); else n_pass++;
        en = 1'b0;
        step();
        // start held during RUN
        load(8'h01);
        start = 1'b1; mode = MODE_ROL; burst_len = 4'd2; en = 1'b1;
        step();
        mode = MODE_CLR; burst_len = 4'd9;
        step();
        n_checks++; if (q !== 8'h02 || busy !== 1'b1)
            $display("FAIL start_in_run1: got q=%h busy=%b expected 02 1", q, busy); else n_pass++;
        step();
        start = 1'b0;
        n_checks++; if (q !== 8'h04 || done !== 1'b1)
            $display("FAIL start_in_run2: got q=%h done=%b expected 04 1", q, done); else n_pass++;
        en = 1'b0;
        step();
        n_checks++; if (q !== 8'h04 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL start_in_run3: got q=%h busy=%b done=%b expected 04 0 0", q, busy, done); else n_pass++;
        $display("edge: start during run ignored -> q=%h", q);
    endtask

    task automatic test_abort();
        load(8'hFF);
        start = 1'b1; mode = MODE_SHL; sin_r = 1'b0; burst_len = 4'd8; en = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        n_checks++; if (q !== 8'hF8 || busy !== 1'b1)
            $display("FAIL abort_pre: got q=%h busy=%b expected f8 1", q, busy); else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_reset: got q=%h busy=%b done=%b expected 00 0 0", q, busy, done); else n_pass++;
        @(negedge clk) rst = 1'b0;
        mode = MODE_HOLD;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00)
                $display("FAIL abort_idle%0d: got done=%b busy=%b q=%h expected 0 0 00", i, done, busy, q); else n_pass++;
        end
        load(8'h81);
        start = 1'b1; mode = MODE_ROL; burst_len = 4'd2; en = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        n_checks++; if (q !== 8'h06 || done !== 1'b1)
            $display("FAIL abort_reburst: got q=%h done=%b expected 06 1", q, done); else n_pass++;
        $display("abort: reset mid-burst then new burst 81 ROL x2 -> q=%h", q);
        en = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_burst_serialise();
        test_burst_stalls();
        test_edge_cases();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register, the next generation of the team's single-bit D flip-flop. It holds a WIDTH-bit word and supports hold, parallel load, logical and arithmetic shifts, rotates and synchronous clear. A small burst engine repeats one operation N times on a single start pulse, with busy/done status. It is used as a serialiser/deserialiser and general data-path register in follow-on designs.

Parameters:
WIDTH, 8, register width in bits (legal range 2 to 64).
CNT_W, $clog2(WIDTH+1), width of burst_len; this is a derived localparam, not user-set.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset; asynchronous, active-high.
en  input  1  operation enable; when low, the register and burst counter hold.
mode  input  3  operation select (encodings under Behaviour).
d  input  WIDTH  parallel load data.
sin_l  input  1  serial input entering at the MSB on SHR.
sin_r  input  1  serial input entering at the LSB on SHL.
start  input  1  burst start pulse; sampled only in IDLE.
burst_len  input  CNT_W  number of operations in the burst.
q  output  WIDTH  register contents.
sout_l  output  1  equals q[WIDTH-1], combinational from q.
sout_r  output  1  equals q[0], combinational from q.
busy  output  1  high while in the RUN state.
done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- rst=1 (asynchronous) forces q=0, busy=0, done=0, state=IDLE, cnt=0 immediately. Reset mid-burst aborts the burst; no done is produced.
- Mode encodings:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q<=d.
  - 010 SHL: q<={q[W-2:0],sin_r}.
  - 011 SHR: q<={sin_l,q[W-1:1]}.
  - 100 ROL: q<={q[W-2:0],q[W-1]}.
  - 101 ROR: q<={q[0],q[W-1:1]}.
  - 110 ASR: q<={q[W-1],q[W-1:1]}.
  - 111 CLR: q<=0.
- IDLE state:
  - If start=0 and en=1, apply mode at the clock edge (single-cycle latency). If en=0, hold.
  - If start=1, this takes priority over en. Latch mode into op_r and burst_len into cnt; q does not change this cycle.
  - If burst_len=0, go to DONE. Otherwise go to RUN.
- RUN state (busy=1):
  - Each cycle with en=1, apply op_r to q and decrement cnt.
  - en=0 stalls: q and cnt hold, busy stays 1.
  - The mode and start inputs are ignored.
  - When cnt==1 and en=1, apply the final operation and go to DONE.
- DONE state: done=1 and busy=0 for exactly one cycle, then go to IDLE. An en or start presented in DONE is ignored.
- Burst latency: the start edge, then burst_len enabled cycles, then done high in the following cycle.
- burst_len greater than WIDTH is legal. Extra shifts keep filling with serial input or the sign bit; rotates wrap modulo WIDTH.
- The counter never wraps: cnt is only decremented while nonzero in RUN.
- All state updates occur on the rising edge of clk. sout_l and sout_r always reflect the current q.

Decomposition:
- Shared package univ_shift_pkg contains:
  - the mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR;
  - the state encodings: ST_IDLE, ST_RUN, ST_DONE.
- One combinational sub-module, shift_next (inputs q, mode, d, sin_l, sin_r; output nxt), computes the next value. It is shared between the single-step path and the burst path.
- The top level holds the q register, the FSM, cnt and op_r.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle with q=8'hA5 -> q=00, busy=0, done=0 without waiting for a clock edge. Release rst, then apply LOAD d=8'h3C -> q=3C after one edge.
2. Single-step modes on q=8'h96:
   - SHL sin_r=1 -> 2D.
   - SHR sin_l=0 -> 4B.
   - ROL -> 2D.
   - ROR -> 4B.
   - ASR -> CB.
   - CLR -> 00.
   - en=0 with any mode -> q unchanged.
3. Burst serialise: load q=8'hB4, then start with mode=SHL, sin_r=0, burst_len=8. Required response:
   - sout_l sequence 1,0,1,1,0,1,0,0;
   - busy high for 8 cycles;
   - done pulses one cycle after the final shift;
   - q=00 at the end.
4. Burst with stalls: ROR with burst_len=3 on q=8'h01, en toggled 1,0,1,0,1 -> q=20 after the third enabled cycle. busy stays 1 through the stalls. mode changes during RUN have no effect.
5. Edge cases:
   - start with burst_len=0 -> done pulses on the next cycle; q and busy unchanged.
   - start and en together in IDLE -> no single-step op occurs.
   - start asserted during RUN -> ignored.
6. Abort: rst during RUN with cnt=5 -> q=00, IDLE, and no done pulse. A new burst afterwards completes normally.
